// File: rtl/l2_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : l2_wb_pkg
// Description : Shared types and constants for the L2 writeback buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package l2_wb_pkg;

  localparam int LINE_BITS = 256;
  localparam int BEAT_BITS = 64;
  localparam int BEATS     = 4;
  // Tag width matches the default 5-bit line offset (32 - 5).
  localparam int TAG_BITS  = 27;

  // Drain state machine encoding.
  typedef logic [0:0] wb_state_t;
  localparam wb_state_t WB_IDLE  = 1'b0;
  localparam wb_state_t WB_BURST = 1'b1;

  // One buffered dirty line.
  typedef struct packed {
    logic                 valid;
    logic [TAG_BITS-1:0]  tag;
    logic [LINE_BITS-1:0] data;
  } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/wb_lookup.sv
`default_nettype none
// ============================================================================
// Module      : wb_lookup
// Description : Combinational tag match over all buffered lines. When the
//               same line is buffered more than once, the youngest copy wins.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_lookup
  import l2_wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  wb_entry_t                   entries [DEPTH],
  input  logic [$clog2(DEPTH)-1:0]    head,
  input  logic [$clog2(DEPTH):0]      count,
  input  logic [TAG_BITS-1:0]         tag,
  output logic                        hit,
  output logic [LINE_BITS-1:0]        data
);

  localparam int c_PTR_W = $clog2(DEPTH);

  logic [c_PTR_W-1:0] w_idx;

  // Walk entries oldest to youngest; a later match overrides an earlier one.
  always_comb begin
    hit   = 1'b0;
    data  = '0;
    w_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = head + i[c_PTR_W-1:0];
      if ((i < int'(count)) && entries[w_idx].valid &&
          (entries[w_idx].tag == tag)) begin
        hit  = 1'b1;
        data = entries[w_idx].data;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/l2_writeback_buffer.sv
`default_nettype none
// ============================================================================
// Module      : l2_writeback_buffer
// Description : FIFO of evicted dirty L2 lines, drained to memory as 4-beat
//               64-bit write bursts, with a combinational forwarding lookup.
// Revision    : 1.0 - initial release
// ============================================================================
module l2_writeback_buffer
  import l2_wb_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int S_OFFSET = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wb_valid,
  input  logic [31:0]           wb_addr,
  input  logic [LINE_BITS-1:0]  wb_data,
  output logic                  wb_ready,
  input  logic [31:0]           lookup_addr,
  output logic                  lookup_hit,
  output logic [LINE_BITS-1:0]  lookup_data,
  input  logic                  drain_hold,
  output logic                  pmem_write,
  output logic [31:0]           pmem_address,
  output logic [BEAT_BITS-1:0]  pmem_wdata,
  input  logic                  pmem_resp,
  output logic                  empty
);

  localparam int                 c_PTR_W     = $clog2(DEPTH);
  localparam logic [c_PTR_W:0]   c_DEPTH_CNT = (c_PTR_W+1)'(DEPTH);
  localparam logic [1:0]         c_LAST_BEAT = 2'(BEATS - 1);

  wb_entry_t            r_entries [DEPTH];
  logic [c_PTR_W-1:0]   r_head;
  logic [c_PTR_W-1:0]   r_tail;
  logic [c_PTR_W:0]     r_count;
  logic [1:0]           r_beat;
  wb_state_t            r_state;

  logic                 w_push;
  logic                 w_pop;
  wb_entry_t            w_head_entry;
  logic                 w_unused_low_bits;

  // Offset bits of both addresses carry no information for line tracking.
  assign w_unused_low_bits = ^{wb_addr[S_OFFSET-1:0], lookup_addr[S_OFFSET-1:0]};

  // Readiness and emptiness come from registered count only, so a pop never
  // frees a slot for a push in the same cycle.
  assign wb_ready     = (r_count < c_DEPTH_CNT);
  assign empty        = (r_count == '0);
  assign w_push       = wb_valid && wb_ready;
  assign w_pop        = (r_state == WB_BURST) && pmem_resp && (r_beat == c_LAST_BEAT);
  assign w_head_entry = r_entries[r_head];

  assign pmem_write   = (r_state == WB_BURST);
  assign pmem_address = pmem_write ? {w_head_entry.tag, {S_OFFSET{1'b0}}} : 32'h0;
  assign pmem_wdata   = pmem_write ? w_head_entry.data[BEAT_BITS*r_beat +: BEAT_BITS]
                                   : '0;

  // Line storage: write at tail on push, invalidate head on pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_entries[i] <= '0;
      end
    end else begin
      if (w_pop) begin
        r_entries[r_head].valid <= 1'b0;
      end
      if (w_push) begin
        r_entries[r_tail] <= '{valid: 1'b1, tag: wb_addr[31:S_OFFSET], data: wb_data};
      end
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Drain FSM: a burst starts only from IDLE, then runs to completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= WB_IDLE;
      r_beat  <= 2'd0;
    end else begin
      case (r_state)
        WB_IDLE: begin
          r_beat <= 2'd0;
          if ((r_count != '0) && !drain_hold) r_state <= WB_BURST;
        end
        WB_BURST: begin
          if (pmem_resp) begin
            r_beat <= r_beat + 2'd1;
            if (r_beat == c_LAST_BEAT) r_state <= WB_IDLE;
          end
        end
        default: begin
          r_state <= WB_IDLE;
          r_beat  <= 2'd0;
        end
      endcase
    end
  end

  wb_lookup #(
    .DEPTH (DEPTH)
  ) u_lookup (
    .entries (r_entries),
    .head    (r_head),
    .count   (r_count),
    .tag     (lookup_addr[31:S_OFFSET]),
    .hit     (lookup_hit),
    .data    (lookup_data)
  );

endmodule
`default_nettype wire

// File: tb/tb_l2_writeback_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_l2_writeback_buffer
// Description : Directed self-checking bench for l2_writeback_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_l2_writeback_buffer;

  logic         clk = 1'b0;
  logic         reset;
  logic         wb_valid;
  logic [31:0]  wb_addr;
  logic [255:0] wb_data;
  logic         wb_ready;
  logic [31:0]  lookup_addr;
  logic         lookup_hit;
  logic [255:0] lookup_data;
  logic         drain_hold;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [63:0]  pmem_wdata;
  logic         pmem_resp;
  logic         empty;

  int n_cmp  = 0;
  int n_fail = 0;

  l2_writeback_buffer #(
    .DEPTH    (2),
    .S_OFFSET (5)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wb_valid     (wb_valid),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .wb_ready     (wb_ready),
    .lookup_addr  (lookup_addr),
    .lookup_hit   (lookup_hit),
    .lookup_data  (lookup_data),
    .drain_hold   (drain_hold),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_resp    (pmem_resp),
    .empty        (empty)
  );

  always #5 clk = ~clk;

  // Beat k of the line is the byte (b+k) repeated eight times.
  function automatic logic [255:0] mkline(input logic [7:0] b);
    logic [255:0] l;
    for (int k = 0; k < 4; k++) l[64*k +: 64] = {8{b + 8'(k)}};
    return l;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [255:0] d);
    wb_valid = 1'b1;
    wb_addr  = a;
    wb_data  = d;
    tick();
    wb_valid = 1'b0;
  endtask

  // Wait (bounded) for a burst, then check address and every beat, holding
  // pmem_resp low for 'gap' cycles per beat to confirm the beat data holds.
  task automatic expect_burst(input logic [31:0] a, input logic [255:0] line,
                              input int gap, input string nm);
    int waits = 0;
    while (pmem_write !== 1'b1 && waits < 20) begin
      tick();
      waits++;
    end
    n_cmp++;
    if (pmem_write !== 1'b1) begin
      n_fail++;
      $display("FAIL %s start: pmem_write=%b expected 1", nm, pmem_write);
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_cmp++;
        if (pmem_address !== a) begin
          n_fail++;
          $display("FAIL %s addr beat%0d: got %h expected %h", nm, k, pmem_address, a);
        end
        n_cmp++;
        if (pmem_wdata !== line[64*k +: 64]) begin
          n_fail++;
          $display("FAIL %s wdata beat%0d: got %h expected %h", nm, k, pmem_wdata, line[64*k +: 64]);
        end
        for (int g = 0; g < gap; g++) begin
          tick();
          n_cmp++;
          if (pmem_wdata !== line[64*k +: 64] || pmem_write !== 1'b1) begin
            n_fail++;
            $display("FAIL %s hold beat%0d: got %h/%b expected %h/1", nm, k, pmem_wdata, pmem_write, line[64*k +: 64]);
          end
        end
        pmem_resp = 1'b1;
        tick();
        pmem_resp = 1'b0;
      end
      n_cmp++;
      if (pmem_write !== 1'b0) begin
        n_fail++;
        $display("FAIL %s end: pmem_write=%b expected 0", nm, pmem_write);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
    lookup_addr = '0; drain_hold = 1'b0; pmem_resp = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    n_cmp++; if (pmem_write !== 1'b0) begin n_fail++; $display("FAIL reset pmem_write: got %b expected 0", pmem_write); end
    n_cmp++; if (pmem_address !== 32'h0) begin n_fail++; $display("FAIL reset pmem_address: got %h expected 0", pmem_address); end
    n_cmp++; if (pmem_wdata !== 64'h0) begin n_fail++; $display("FAIL reset pmem_wdata: got %h expected 0", pmem_wdata); end
    n_cmp++; if (wb_ready !== 1'b1) begin n_fail++; $display("FAIL reset wb_ready: got %b expected 1", wb_ready); end
    n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset empty: got %b expected 1", empty); end
    n_cmp++; if (lookup_hit !== 1'b0) begin n_fail++; $display("FAIL reset lookup_hit: got %b expected 0", lookup_hit); end
  endtask

  task automatic test_single();
    logic [255:0] la;
    la = mkline(8'h00);
    pmem_resp = 1'b0;
    push(32'h0000_1040, la);
    n_cmp++; if (pmem_write !== 1'b0 || empty !== 1'b0) begin n_fail++; $display("FAIL single after_push: write/empty=%b%b expected 00", pmem_write, empty); end
    tick();
    n_cmp++; if (pmem_write !== 1'b1) begin n_fail++; $display("FAIL single rise: pmem_write=%b expected 1", pmem_write); end
    expect_burst(32'h0000_1040, la, 0, "single");
    n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL single empty: got %b expected 1", empty); end
  endtask

  task automatic test_back_to_back();
    logic [255:0] la, lb, lc;
    la = mkline(8'h10); lb = mkline(8'h20); lc = mkline(8'h30);
    drain_hold = 1'b1;
    push(32'h0000_0100, la);
    n_cmp++; if (wb_ready !== 1'b1) begin n_fail++; $display("FAIL b2b ready_one: got %b expected 1", wb_ready); end
    push(32'h0000_0200, lb);
    n_cmp++; if (wb_ready !== 1'b0) begin n_fail++; $display("FAIL b2b ready_full: got %b expected 0", wb_ready); end
    push(32'h0000_0300, lc);
    lookup_addr = 32'h0000_0300;
    #1;
    n_cmp++; if (lookup_hit !== 1'b0) begin n_fail++; $display("FAIL b2b c_dropped: lookup_hit=%b expected 0", lookup_hit); end
    n_cmp++; if (pmem_write !== 1'b0) begin n_fail++; $display("FAIL b2b held: pmem_write=%b expected 0", pmem_write); end
    drain_hold = 1'b0;
    expect_burst(32'h0000_0100, la, 0, "b2b_A");
    tick();
    n_cmp++; if (pmem_write !== 1'b1) begin n_fail++; $display("FAIL b2b one_idle: pmem_write=%b expected 1", pmem_write); end
    expect_burst(32'h0000_0200, lb, 0, "b2b_B");
    tick(); tick(); tick();
    n_cmp++; if (pmem_write !== 1'b0 || empty !== 1'b1) begin n_fail++; $display("FAIL b2b no_c: write/empty=%b%b expected 01", pmem_write, empty); end
  endtask

  task automatic test_lookup();
    logic [255:0] d1, d2;
    d1 = mkline(8'h40); d2 = mkline(8'h50);
    drain_hold = 1'b1;
    push(32'h0000_3000, d1);
    push(32'h0000_3000, d2);
    lookup_addr = 32'h0000_3014;
    #1;
    n_cmp++; if (lookup_hit !== 1'b1) begin n_fail++; $display("FAIL lookup hit: got %b expected 1", lookup_hit); end
    n_cmp++; if (lookup_data !== d2) begin n_fail++; $display("FAIL lookup youngest: got %h expected %h", lookup_data, d2); end
    lookup_addr = 32'h0000_3020;
    #1;
    n_cmp++; if (lookup_hit !== 1'b0 || lookup_data !== 256'h0) begin n_fail++; $display("FAIL lookup miss: hit=%b data=%h expected 0/0", lookup_hit, lookup_data); end
    drain_hold = 1'b0;
    expect_burst(32'h0000_3000, d1, 0, "lookup_D1");
    expect_burst(32'h0000_3000, d2, 0, "lookup_D2");
    lookup_addr = 32'h0000_3014;
    #1;
    n_cmp++; if (lookup_hit !== 1'b0 || lookup_data !== 256'h0) begin n_fail++; $display("FAIL lookup drained: hit=%b data=%h expected 0/0", lookup_hit, lookup_data); end
  endtask

  task automatic test_stall();
    logic [255:0] l4, l5;
    int bad;
    l4 = mkline(8'h60); l5 = mkline(8'h70);
    drain_hold = 1'b0;
    push(32'h0000_4000, l4);
    tick();
    drain_hold = 1'b1;
    push(32'h0000_5000, l5);
    lookup_addr = 32'h0000_4000;
    #1;
    n_cmp++; if (lookup_hit !== 1'b1 || lookup_data !== l4) begin n_fail++; $display("FAIL stall drain_match: hit=%b data=%h expected 1/%h", lookup_hit, lookup_data, l4); end
    expect_burst(32'h0000_4000, l4, 3, "stall");
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (pmem_write !== 1'b0) bad++;
      tick();
    end
    n_cmp++; if (bad != 0 || empty !== 1'b0) begin n_fail++; $display("FAIL stall held: %0d burst cycles, empty=%b expected 0/0", bad, empty); end
    drain_hold = 1'b0;
    expect_burst(32'h0000_5000, l5, 0, "stall_next");
  endtask

  task automatic test_full_wrap();
    logic [255:0] ln [6];
    logic [31:0]  an [6];
    for (int i = 0; i < 6; i++) begin
      ln[i] = mkline(8'h80 + 8'(8*i));
      an[i] = 32'h0000_6000 + 32'(i * 32);
    end
    drain_hold = 1'b1;
    push(an[0], ln[0]);
    push(an[1], ln[1]);
    drain_hold = 1'b0;
    tick();
    pmem_resp = 1'b1;
    tick(); tick(); tick();
    n_cmp++; if (pmem_wdata !== ln[0][192 +: 64]) begin n_fail++; $display("FAIL wrap beat3: got %h expected %h", pmem_wdata, ln[0][192 +: 64]); end
    wb_valid = 1'b1; wb_addr = an[2]; wb_data = ln[2];
    n_cmp++; if (wb_ready !== 1'b0) begin n_fail++; $display("FAIL wrap ready_at_pop: got %b expected 0", wb_ready); end
    tick();
    pmem_resp = 1'b0;
    n_cmp++; if (wb_ready !== 1'b1 || pmem_write !== 1'b0) begin n_fail++; $display("FAIL wrap after_pop: ready/write=%b%b expected 10", wb_ready, pmem_write); end
    tick();
    wb_valid = 1'b0;
    n_cmp++; if (wb_ready !== 1'b0) begin n_fail++; $display("FAIL wrap accepted: wb_ready=%b expected 0", wb_ready); end
    expect_burst(an[1], ln[1], 0, "wrap_L1");
    push(an[3], ln[3]);
    expect_burst(an[2], ln[2], 0, "wrap_L2");
    expect_burst(an[3], ln[3], 0, "wrap_L3");
    push(an[4], ln[4]);
    push(an[5], ln[5]);
    expect_burst(an[4], ln[4], 0, "wrap_L4");
    expect_burst(an[5], ln[5], 0, "wrap_L5");
    tick();
    n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL wrap empty: got %b expected 1", empty); end
  endtask

  task automatic test_async_reset();
    logic [255:0] l7;
    int bad;
    l7 = mkline(8'hE0);
    drain_hold = 1'b0;
    push(32'h0000_7000, l7);
    tick();
    pmem_resp = 1'b1;
    tick(); tick();
    pmem_resp = 1'b0;
    n_cmp++; if (pmem_wdata !== l7[128 +: 64]) begin n_fail++; $display("FAIL areset beat2: got %h expected %h", pmem_wdata, l7[128 +: 64]); end
    #3;
    reset = 1'b1;
    #1;
    n_cmp++; if (pmem_write !== 1'b0 || empty !== 1'b1) begin n_fail++; $display("FAIL areset immediate: write/empty=%b%b expected 01", pmem_write, empty); end
    #10;
    reset = 1'b0;
    lookup_addr = 32'h0000_7000;
    pmem_resp = 1'b1;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (pmem_write !== 1'b0 || lookup_hit !== 1'b0) bad++;
    end
    pmem_resp = 1'b0;
    n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL areset residue: %0d bad cycles expected 0", bad); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_lookup();
    test_stall();
    test_full_wrap();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
